gray_sync_decoder: RTL and testbench

Receive-side counterpart to the Gray-code encoder path. It samples a Gray-coded count arriving from an unrelated domain and synchronizes it through a flop chain. It then checks that every change is a legal single-bit Gray step and converts the value to binary. The result goes to local logic as a registered binary value with a step size and error status. It sits at the destination end of any Gray-coded pointer or counter crossing, for example FIFO pointers or free-running timestamps.

---
 rtl/gray_sync_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_gray_sync_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_sync_decoder.sv
// Purpose: synchronize a Gray-coded count from a foreign domain, validate single-bit steps, convert to binary.
// Latency: gray_in captured at edge n appears on bin_out/bin_valid after edge n+SYNC_STAGES (locked, legal step).
// Backpressure: none; the consumer cannot stall, and bin_valid/step_err are single-cycle registered pulses.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   gray_in    Gray-coded value from the foreign domain (may change at any time)
//   bin_out    last accepted value, binary
//   delta      (new - previous) mod 2^DATA_WIDTH for the last accepted step
//   bin_valid  one-cycle pulse when bin_out/delta update
//   locked     high while the decoder trusts the incoming sequence
//   step_err   one-cycle pulse on a multi-bit transition
//   err_count  saturating count of step_err pulses
module gray_sync_decoder #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] gray_in,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic [DATA_WIDTH-1:0] delta,
  output logic                  bin_valid,
  output logic                  locked,
  output logic                  step_err,
  output logic [7:0]            err_count
);

  // The stable counter only ever holds 0..STABLE_CYCLES-1; it is cleared on lock.
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] g_s;
  logic [DATA_WIDTH-1:0] g_ref_q, g_ref_d;
  logic [CNT_W-1:0]      stable_cnt_q, stable_cnt_d;
  logic [DATA_WIDTH-1:0] bin_out_q, bin_out_d;
  logic [DATA_WIDTH-1:0] delta_q, delta_d;
  logic                  bin_valid_q, bin_valid_d;
  logic                  step_err_q, step_err_d;
  logic [7:0]            err_count_q, err_count_d;

  logic [DATA_WIDTH-1:0] diff;
  logic [DATA_WIDTH-1:0] bin_s;
  logic                  hd_zero;
  logic                  hd_one;
  logic                  hd_multi;

  // Bit i of the binary value is the XOR of all Gray bits at and above i.
  function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] b;
    b = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Synchronizer chain; stage 0 is the only flop that sees the foreign domain.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign g_s   = sync_q[SYNC_STAGES-1];
  assign bin_s = gray2bin(g_s);
  assign diff  = g_s ^ g_ref_q;

  // Hamming distance classified as 0 / 1 / >=2: a non-zero vector with a
  // single set bit is a power of two, so clearing its lowest set bit leaves 0.
  assign hd_zero  = (diff == '0);
  assign hd_one   = !hd_zero && ((diff & (diff - DATA_WIDTH'(1))) == '0);
  assign hd_multi = !hd_zero && !hd_one;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (hd_zero && (stable_cnt_q == CNT_LAST)) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (hd_multi) begin
          state_d = ST_UNLOCKED;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    g_ref_d      = g_ref_q;
    stable_cnt_d = stable_cnt_q;
    bin_out_d    = bin_out_q;
    delta_d      = delta_q;
    bin_valid_d  = 1'b0;
    step_err_d   = 1'b0;
    err_count_d  = err_count_q;

    case (state_q)
      ST_UNLOCKED: begin
        if (hd_zero) begin
          if (stable_cnt_q == CNT_LAST) begin
            // Lock: publish the settled value; no step has been taken yet.
            bin_out_d    = bin_s;
            delta_d      = '0;
            bin_valid_d  = 1'b1;
            stable_cnt_d = '0;
          end else begin
            stable_cnt_d = stable_cnt_q + CNT_W'(1);
          end
        end else begin
          // Input still moving: restart the stability window on the new value.
          g_ref_d      = g_s;
          stable_cnt_d = '0;
        end
      end

      ST_LOCKED: begin
        if (hd_one) begin
          g_ref_d     = g_s;
          bin_out_d   = bin_s;
          delta_d     = bin_s - bin_out_q;  // modulo 2^W: wrap gives 1, backward gives all-ones
          bin_valid_d = 1'b1;
        end else if (hd_multi) begin
          // Published outputs are left untouched; only the reference moves.
          step_err_d   = 1'b1;
          err_count_d  = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
          g_ref_d      = g_s;
          stable_cnt_d = '0;
        end
      end

      default: begin
        g_ref_d      = g_s;
        stable_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_ref_q      <= '0;
      stable_cnt_q <= '0;
      bin_out_q    <= '0;
      delta_q      <= '0;
      bin_valid_q  <= 1'b0;
      step_err_q   <= 1'b0;
      err_count_q  <= 8'h00;
    end else begin
      g_ref_q      <= g_ref_d;
      stable_cnt_q <= stable_cnt_d;
      bin_out_q    <= bin_out_d;
      delta_q      <= delta_d;
      bin_valid_q  <= bin_valid_d;
      step_err_q   <= step_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bin_out   = bin_out_q;
  assign delta     = delta_q;
  assign bin_valid = bin_valid_q;
  assign step_err  = step_err_q;
  assign err_count = err_count_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Purpose: directed self-checking bench for gray_sync_decoder (W=8 and W=4 instances).
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: not applicable; every wait on the DUT is bounded by a cycle budget.
module tb_gray_sync_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] gray8, bin8, delta8, errc8;
  logic       vld8, lock8, err8;
  logic [3:0] gray4, bin4, delta4;
  logic [7:0] errc4;
  logic       vld4, lock4, err4;

  int n_checks = 0;
  int n_errors = 0;

  gray_sync_decoder #(.DATA_WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray8), .bin_out(bin8), .delta(delta8),
    .bin_valid(vld8), .locked(lock8), .step_err(err8), .err_count(errc8)
  );

  gray_sync_decoder #(.DATA_WIDTH(4), .SYNC_STAGES(2), .STABLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .gray_in(gray4), .bin_out(bin4), .delta(delta4),
    .bin_valid(vld4), .locked(lock4), .step_err(err4), .err_count(errc4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand table of Gray codes for 0..19 (i ^ i>>1).
  logic [7:0] gtab [20] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04,
                            8'h0C, 8'h0D, 8'h0F, 8'h0E, 8'h0A, 8'h0B, 8'h09, 8'h08,
                            8'h18, 8'h19, 8'h1B, 8'h1A};

  // Legal step on the 8-bit instance: pulse appears on the third edge after the change.
  task automatic step8(input string tag, input logic [7:0] g, input logic [7:0] eb, input logic [7:0] ed);
    gray8 = g;
    tick();
    tick();
    chk({tag, "_early_vld"}, 32'(vld8), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(vld8), 32'd1);
    chk({tag, "_bin"}, 32'(bin8), 32'(eb));
    chk({tag, "_delta"}, 32'(delta8), 32'(ed));
  endtask

  task automatic step4(input string tag, input logic [3:0] g, input logic [3:0] eb, input logic [3:0] ed);
    gray4 = g;
    tick();
    tick();
    tick();
    chk({tag, "_vld"}, 32'(vld4), 32'd1);
    chk({tag, "_bin"}, 32'(bin4), 32'(eb));
    chk({tag, "_delta"}, 32'(delta4), 32'(ed));
  endtask

  initial begin
    int vld_cnt;
    int err_cnt;
    logic seen;

    rst_n = 1'b0;
    gray8 = 8'h00;
    gray4 = 4'h0;

    // ---------------- reset state ----------------
    #12;
    chk("rst_bin", 32'(bin8), 32'd0);
    chk("rst_delta", 32'(delta8), 32'd0);
    chk("rst_lock", 32'(lock8), 32'd0);
    chk("rst_vld", 32'(vld8), 32'd0);
    chk("rst_err", 32'(err8), 32'd0);
    chk("rst_errc", 32'(errc8), 32'd0);

    // ---------------- reset lock ----------------
    tick();
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("lock_3rd_edge", 32'(lock8), 32'd0);
    chk("lock_3rd_vld", 32'(vld8), 32'd0);
    tick();
    chk("lock_4th_edge", 32'(lock8), 32'd1);
    chk("lock_vld", 32'(vld8), 32'd1);
    chk("lock_bin", 32'(bin8), 32'd0);
    chk("lock_delta", 32'(delta8), 32'd0);
    chk("lock4_edge", 32'(lock4), 32'd1);
    tick();
    chk("lock_vld_pulse_end", 32'(vld8), 32'd0);

    // ---------------- illegal jump 0x00 -> 0x03 ----------------
    gray8 = 8'h03;
    tick(); tick();
    chk("ill_err_early", 32'(err8), 32'd0);
    tick();
    chk("ill_err", 32'(err8), 32'd1);
    chk("ill_errc", 32'(errc8), 32'd1);
    chk("ill_lock", 32'(lock8), 32'd0);
    chk("ill_bin_hold", 32'(bin8), 32'd0);
    chk("ill_vld", 32'(vld8), 32'd0);
    tick();
    chk("ill_err_pulse_end", 32'(err8), 32'd0);
    tick(); tick();
    chk("relock_3rd", 32'(lock8), 32'd0);
    tick();
    chk("relock_4th", 32'(lock8), 32'd1);
    chk("relock_vld", 32'(vld8), 32'd1);
    chk("relock_bin", 32'(bin8), 32'd2);
    chk("relock_delta", 32'(delta8), 32'd0);

    // ---------------- forward then backward steps ----------------
    step8("fwd_2to3", 8'h02, 8'd3, 8'd1);
    step8("back_3to2", 8'h03, 8'd2, 8'hFF);
    step8("back_2to1", 8'h01, 8'd1, 8'hFF);
    step8("back_1to0", 8'h00, 8'd0, 8'hFF);

    // ---------------- counting 0..19 ----------------
    vld_cnt = 0;
    err_cnt = 0;
    for (int i = 1; i < 20; i++) begin
      gray8 = gtab[i];
      for (int c = 0; c < 3; c++) begin
        tick();
        if (vld8) vld_cnt++;
        if (err8) err_cnt++;
      end
      chk($sformatf("cnt_bin_%0d", i), 32'(bin8), 32'(i));
      chk($sformatf("cnt_delta_%0d", i), 32'(delta8), 32'd1);
    end
    chk("cnt_pulses", 32'(vld_cnt), 32'd19);
    chk("cnt_no_err", 32'(err_cnt), 32'd0);

    // ---------------- W=4 wrap ----------------
    gray4 = 4'hB;
    tick(); tick(); tick();
    chk("w4_jump_err", 32'(err4), 32'd1);
    tick(); tick(); tick(); tick();
    chk("w4_relock", 32'(lock4), 32'd1);
    chk("w4_relock_bin", 32'(bin4), 32'd13);
    chk("w4_relock_delta", 32'(delta4), 32'd0);
    step4("w4_13to14", 4'h9, 4'd14, 4'd1);
    step4("w4_14to15", 4'h8, 4'd15, 4'd1);
    step4("w4_15to0", 4'h0, 4'd0, 4'd1);
    step4("w4_0to1", 4'h1, 4'd1, 4'd1);
    chk("w4_errc", 32'(errc4), 32'd1);

    // ---------------- err_count saturation ----------------
    for (int k = 1; k <= 300; k++) begin
      gray8 = (k % 2 == 1) ? 8'h03 : 8'h00;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
        tick();
        if (err8) seen = 1'b1;
      end
      chk($sformatf("sat_err_%0d", k), 32'(seen), 32'd1);
      if (k == 200) chk("sat_errc_200", 32'(errc8), 32'd201);
      if (k == 254) chk("sat_errc_254", 32'(errc8), 32'd255);
      for (int t = 0; t < 10 && !lock8; t++) tick();
      chk($sformatf("sat_relock_%0d", k), 32'(lock8), 32'd1);
    end
    chk("sat_errc_final", 32'(errc8), 32'd255);

    // ---------------- walk to 7, then async reset mid-cycle ----------------
    for (int i = 1; i < 8; i++) begin
      step8($sformatf("walk_%0d", i), gtab[i], 8'(i), 8'd1);
    end
    chk("walk_lock", 32'(lock8), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_bin", 32'(bin8), 32'd0);
    chk("arst_delta", 32'(delta8), 32'd0);
    chk("arst_lock", 32'(lock8), 32'd0);
    chk("arst_vld", 32'(vld8), 32'd0);
    chk("arst_err", 32'(err8), 32'd0);
    chk("arst_errc", 32'(errc8), 32'd0);
    gray8 = 8'h00;
    gray4 = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("arst_relock_3rd", 32'(lock8), 32'd0);
    tick();
    chk("arst_relock_4th", 32'(lock8), 32'd1);
    chk("arst_relock_vld", 32'(vld8), 32'd1);
    chk("arst_relock_bin", 32'(bin8), 32'd0);
    chk("arst_relock_delta", 32'(delta8), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
